// File: rtl/ps2_kbd_ctrl_pkg.sv
// rtl/ps2_kbd_ctrl_pkg.sv - shared constants and types for the PS/2 keyboard controller
package ps2_pkg;

    localparam logic [7:0] PS2_EXT  = 8'hE0;
    localparam logic [7:0] PS2_BRK  = 8'hF0;
    localparam logic [7:0] PS2_ERR0 = 8'h00;
    localparam logic [7:0] PS2_ERR1 = 8'hFF;

    typedef enum logic [1:0] {
        ST_WAIT   = 2'd0,
        ST_POP    = 2'd1,
        ST_SETTLE = 2'd2
    } state_t;

    typedef struct packed {
        logic       ext;
        logic [7:0] code;
    } key_id_t;

endpackage

// File: rtl/ps2_kbd_ctrl_if.sv
// rtl/ps2_kbd_ctrl_if.sv - key event valid/ready stream between controller and consumer
interface ps2_kbd_ctrl_if;
    logic       ev_valid;
    logic       ev_ready;
    logic [7:0] ev_code;
    logic       ev_ext;
    logic       ev_break;
    logic       ev_repeat;

    modport master (output ev_valid, ev_code, ev_ext, ev_break, ev_repeat, input ev_ready);
    modport slave  (input ev_valid, ev_code, ev_ext, ev_break, ev_repeat, output ev_ready);
endinterface

// File: rtl/ps2_key_tracker.sv
// rtl/ps2_key_tracker.sv - held-key tracking, typematic repeat detection and press counting
module ps2_key_tracker
    import ps2_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_ev_stb,
    input  logic             i_brk,
    input  key_id_t          i_key,
    output logic             o_repeat,
    output logic             o_key_down,
    output key_id_t          o_held_code,
    output logic [CNT_W-1:0] o_press_cnt
);

    logic             r_key_down;
    key_id_t          r_held;
    logic [CNT_W-1:0] r_cnt;
    logic             w_match;

    assign w_match     = (i_key == r_held);
    assign o_repeat    = !i_brk && r_key_down && w_match;
    assign o_key_down  = r_key_down;
    assign o_held_code = r_held;
    assign o_press_cnt = r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_key_down <= 1'b0;
            r_held     <= '0;
            r_cnt      <= '0;
        end else if (i_ev_stb) begin
            if (!i_brk) begin
                if (!(r_key_down && w_match)) begin
                    r_held     <= i_key;
                    r_key_down <= 1'b1;
                    r_cnt      <= r_cnt + 1'b1;
                end
            end else if (w_match) begin
                r_key_down <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/ps2_kbd_ctrl.sv
// rtl/ps2_kbd_ctrl.sv - drains the PS/2 receiver FIFO and turns scan-code bytes into key events
module ps2_kbd_ctrl
    import ps2_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       i_kbd_data,
    input  logic             i_kbd_ready,
    input  logic             i_kbd_overflow,
    output logic             o_kbd_nextdata_n,
    ps2_kbd_ctrl_if.master   ev,
    output logic             o_key_down,
    output logic [8:0]       o_held_code,
    output logic [CNT_W-1:0] o_press_cnt,
    output logic             o_ovf_sticky,
    output logic             o_err
);

    state_t     r_state, w_next;
    logic [7:0] r_byte;
    logic       r_ext_f, r_brk_f;
    logic       r_ev_valid, r_ev_ext, r_ev_brk, r_ev_rep;
    logic [7:0] r_ev_code;
    logic       r_ovf, r_err;
    logic       w_take, w_pop, w_is_ext, w_is_brk, w_is_bad, w_emit, w_err, w_repeat;
    key_id_t    w_held;

    // A pending unaccepted event blocks every pop, prefixes included.
    assign w_take   = i_kbd_ready && !(r_ev_valid && !ev.ev_ready);
    assign w_is_ext = (r_byte == PS2_EXT);
    assign w_is_brk = (r_byte == PS2_BRK);
    assign w_is_bad = (r_byte == PS2_ERR0) || (r_byte == PS2_ERR1);
    assign w_emit   = w_pop && !w_is_ext && !w_is_brk && !w_is_bad;
    assign w_err    = w_pop && (w_is_bad || (w_is_ext && r_brk_f));

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_WAIT;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_WAIT:   if (w_take) w_next = ST_POP;
            ST_POP:    w_next = ST_SETTLE;
            ST_SETTLE: w_next = ST_WAIT;
            default:   w_next = ST_WAIT;
        endcase
    end

    always_comb begin
        w_pop            = (r_state == ST_POP);
        o_kbd_nextdata_n = !w_pop;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_byte     <= '0;
            r_ext_f    <= 1'b0;
            r_brk_f    <= 1'b0;
            r_ev_valid <= 1'b0;
            r_ev_code  <= '0;
            r_ev_ext   <= 1'b0;
            r_ev_brk   <= 1'b0;
            r_ev_rep   <= 1'b0;
            r_ovf      <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_err <= w_err;
            if (i_kbd_overflow) r_ovf <= 1'b1;
            if (r_state == ST_WAIT && w_take) r_byte <= i_kbd_data;
            if (w_pop) begin
                if (w_is_ext) begin
                    r_ext_f <= 1'b1;
                    r_brk_f <= 1'b0;
                end else if (w_is_brk) begin
                    r_brk_f <= 1'b1;
                end else begin
                    r_ext_f <= 1'b0;
                    r_brk_f <= 1'b0;
                end
            end
            if (w_emit) begin
                r_ev_valid <= 1'b1;
                r_ev_code  <= r_byte;
                r_ev_ext   <= r_ext_f;
                r_ev_brk   <= r_brk_f;
                r_ev_rep   <= w_repeat;
            end else if (ev.ev_ready) begin
                r_ev_valid <= 1'b0;
            end
        end
    end

    ps2_key_tracker #(.CNT_W(CNT_W)) u_tracker (
        .clk         (clk),
        .rst         (rst),
        .i_ev_stb    (w_emit),
        .i_brk       (r_brk_f),
        .i_key       ({r_ext_f, r_byte}),
        .o_repeat    (w_repeat),
        .o_key_down  (o_key_down),
        .o_held_code (w_held),
        .o_press_cnt (o_press_cnt)
    );

    assign o_held_code  = w_held;
    assign o_ovf_sticky = r_ovf;
    assign o_err        = r_err;
    assign ev.ev_valid  = r_ev_valid;
    assign ev.ev_code   = r_ev_code;
    assign ev.ev_ext    = r_ev_ext;
    assign ev.ev_break  = r_ev_brk;
    assign ev.ev_repeat = r_ev_rep;

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// tb/tb_ps2_kbd_ctrl.sv - directed self-checking bench for ps2_kbd_ctrl
module tb_ps2_kbd_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] kbd_data;
    logic       kbd_ready;
    logic       kbd_overflow;
    logic       kbd_nextdata_n;
    logic       key_down;
    logic [8:0] held_code;
    logic [7:0] press_cnt;
    logic       ovf_sticky;
    logic       err;

    ps2_kbd_ctrl_if ev_if();

    ps2_kbd_ctrl #(.CNT_W(8)) dut (
        .clk              (clk),
        .rst              (rst),
        .i_kbd_data       (kbd_data),
        .i_kbd_ready      (kbd_ready),
        .i_kbd_overflow   (kbd_overflow),
        .o_kbd_nextdata_n (kbd_nextdata_n),
        .ev               (ev_if),
        .o_key_down       (key_down),
        .o_held_code      (held_code),
        .o_press_cnt      (press_cnt),
        .o_ovf_sticky     (ovf_sticky),
        .o_err            (err)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [7:0]  fifo[$];
    logic [10:0] evq[$];
    int          pop_cnt = 0;
    int          err_cnt = 0;
    int          dbl_low = 0;
    logic        prev_low = 1'b0;

    // Receiver FIFO model and event/err/pop monitors, all on the falling edge.
    always @(negedge clk) begin
        if (!kbd_nextdata_n) begin
            if (prev_low) dbl_low++;
            if (fifo.size() != 0) void'(fifo.pop_front());
            pop_cnt++;
        end
        prev_low = !kbd_nextdata_n;
        if (ev_if.ev_valid && ev_if.ev_ready)
            evq.push_back({ev_if.ev_repeat, ev_if.ev_break, ev_if.ev_ext, ev_if.ev_code});
        if (err) err_cnt++;
        kbd_ready = (fifo.size() != 0);
        kbd_data  = (fifo.size() != 0) ? fifo[0] : 8'h00;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(1);
    endtask

    task automatic drain(input int max_cycles);
        int c = 0;
        while (fifo.size() != 0 && c < max_cycles) begin
            tick(1);
            c++;
        end
        n_tests++;
        if (c >= max_cycles) begin
            n_fail++;
            $display("FAIL drain_timeout: fifo still holds %0d bytes, required 0", fifo.size());
        end
        tick(4);
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++;
        if (kbd_nextdata_n !== 1'b1 || ev_if.ev_valid !== 1'b0 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: nextdata_n=%b ev_valid=%b err=%b, required 1 0 0", kbd_nextdata_n, ev_if.ev_valid, err);
        end
        n_tests++;
        if ({ev_if.ev_code, ev_if.ev_ext, ev_if.ev_break, ev_if.ev_repeat} !== 11'h000) begin
            n_fail++;
            $display("FAIL reset_ev: code=%h ext=%b brk=%b rep=%b, required all 0", ev_if.ev_code, ev_if.ev_ext, ev_if.ev_break, ev_if.ev_repeat);
        end
        n_tests++;
        if (key_down !== 1'b0 || held_code !== 9'h000 || press_cnt !== 8'h00 || ovf_sticky !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_track: key_down=%b held=%h cnt=%h ovf=%b, required 0 000 00 0", key_down, held_code, press_cnt, ovf_sticky);
        end
    endtask

    task automatic test_single_make();
        int eb, pb, db;
        do_reset();
        ev_if.ev_ready = 1'b1;
        eb = evq.size(); pb = pop_cnt; db = dbl_low;
        fifo.push_back(8'h1C);
        tick(1);
        n_tests++;
        if (kbd_nextdata_n !== 1'b0) begin
            n_fail++;
            $display("FAIL single_pop_latency: nextdata_n=%b, required 0", kbd_nextdata_n);
        end
        tick(1);
        n_tests++;
        if (ev_if.ev_valid !== 1'b1 || ev_if.ev_code !== 8'h1C || press_cnt !== 8'd1 || key_down !== 1'b1 || held_code !== 9'h01C) begin
            n_fail++;
            $display("FAIL single_event: valid=%b code=%h cnt=%0d down=%b held=%h, required 1 1c 1 1 01c",
                     ev_if.ev_valid, ev_if.ev_code, press_cnt, key_down, held_code);
        end
        drain(20);
        n_tests++;
        if (evq.size() - eb != 1 || evq[eb] !== 11'h01C) begin
            n_fail++;
            $display("FAIL single_stream: %0d events first=%h, required 1 event 01c", evq.size() - eb, (evq.size() > eb) ? evq[eb] : 11'h7FF);
        end
        n_tests++;
        if (pop_cnt - pb != 1 || dbl_low != db) begin
            n_fail++;
            $display("FAIL single_pop_width: pops=%0d wide_pops=%0d, required 1 0", pop_cnt - pb, dbl_low - db);
        end
    endtask

    task automatic test_repeat();
        logic [10:0] exp_ev [4] = '{11'h01C, 11'h41C, 11'h41C, 11'h21C};
        int eb;
        do_reset();
        ev_if.ev_ready = 1'b1;
        eb = evq.size();
        fifo.push_back(8'h1C); fifo.push_back(8'h1C); fifo.push_back(8'h1C);
        fifo.push_back(8'hF0); fifo.push_back(8'h1C);
        drain(100);
        n_tests++;
        if (evq.size() - eb != 4) begin
            n_fail++;
            $display("FAIL repeat_count: %0d events, required 4", evq.size() - eb);
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_tests++;
                if (evq[eb+i] !== exp_ev[i]) begin
                    n_fail++;
                    $display("FAIL repeat_ev%0d: got %h, required %h", i, evq[eb+i], exp_ev[i]);
                end
            end
        end
        n_tests++;
        if (press_cnt !== 8'd1 || key_down !== 1'b0) begin
            n_fail++;
            $display("FAIL repeat_track: cnt=%0d down=%b, required 1 0", press_cnt, key_down);
        end
    endtask

    task automatic test_extended();
        int eb;
        do_reset();
        ev_if.ev_ready = 1'b1;
        eb = evq.size();
        fifo.push_back(8'hE0); fifo.push_back(8'h75);
        drain(50);
        n_tests++;
        if (held_code !== 9'h175 || key_down !== 1'b1) begin
            n_fail++;
            $display("FAIL ext_make_track: held=%h down=%b, required 175 1", held_code, key_down);
        end
        fifo.push_back(8'hE0); fifo.push_back(8'hF0); fifo.push_back(8'h75);
        drain(50);
        n_tests++;
        if (evq.size() - eb != 2 || evq[eb] !== 11'h175 || evq[eb+1] !== 11'h375) begin
            n_fail++;
            $display("FAIL ext_stream: %0d events, required 2 events 175 375", evq.size() - eb);
        end
        n_tests++;
        if (key_down !== 1'b0 || press_cnt !== 8'd1) begin
            n_fail++;
            $display("FAIL ext_break_track: down=%b cnt=%0d, required 0 1", key_down, press_cnt);
        end
    endtask

    task automatic test_backpressure();
        logic [10:0] exp_ev [4] = '{11'h01C, 11'h032, 11'h232, 11'h021};
        int eb, pb, bad;
        do_reset();
        ev_if.ev_ready = 1'b0;
        eb = evq.size(); pb = pop_cnt; bad = 0;
        fifo.push_back(8'h1C); fifo.push_back(8'h32); fifo.push_back(8'hF0);
        fifo.push_back(8'h32); fifo.push_back(8'h21);
        tick(6);
        for (int i = 0; i < 20; i++) begin
            if (ev_if.ev_valid !== 1'b1 || ev_if.ev_code !== 8'h1C || ev_if.ev_ext !== 1'b0 ||
                ev_if.ev_break !== 1'b0 || pop_cnt - pb != 1) bad++;
            tick(1);
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL bp_stall: %0d unstable or popping cycles, required 0", bad);
        end
        ev_if.ev_ready = 1'b1;
        drain(100);
        n_tests++;
        if (evq.size() - eb != 4) begin
            n_fail++;
            $display("FAIL bp_count: %0d events, required 4", evq.size() - eb);
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_tests++;
                if (evq[eb+i] !== exp_ev[i]) begin
                    n_fail++;
                    $display("FAIL bp_ev%0d: got %h, required %h", i, evq[eb+i], exp_ev[i]);
                end
            end
        end
        n_tests++;
        if (press_cnt !== 8'd3 || key_down !== 1'b1 || held_code !== 9'h021 || pop_cnt - pb != 5) begin
            n_fail++;
            $display("FAIL bp_track: cnt=%0d down=%b held=%h pops=%0d, required 3 1 021 5", press_cnt, key_down, held_code, pop_cnt - pb);
        end
    endtask

    task automatic test_errors();
        int eb, rb;
        do_reset();
        ev_if.ev_ready = 1'b1;
        eb = evq.size(); rb = err_cnt;
        fifo.push_back(8'hF0); fifo.push_back(8'hE0); fifo.push_back(8'h75);
        drain(50);
        n_tests++;
        if (err_cnt - rb != 1 || evq.size() - eb != 1 || evq[eb] !== 11'h175) begin
            n_fail++;
            $display("FAIL err_brk_ext: err_cycles=%0d events=%0d, required 1 and one event 175", err_cnt - rb, evq.size() - eb);
        end
        fifo.push_back(8'hFF);
        drain(50);
        n_tests++;
        if (err_cnt - rb != 2 || evq.size() - eb != 1) begin
            n_fail++;
            $display("FAIL err_ff: err_cycles=%0d events=%0d, required 2 1", err_cnt - rb, evq.size() - eb);
        end
        n_tests++;
        if (ovf_sticky !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_idle: ovf_sticky=%b, required 0", ovf_sticky);
        end
        kbd_overflow = 1'b1;
        tick(1);
        kbd_overflow = 1'b0;
        tick(8);
        n_tests++;
        if (ovf_sticky !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_sticky: ovf_sticky=%b, required 1", ovf_sticky);
        end
    endtask

    task automatic test_wrap_and_reset();
        int eb, c;
        do_reset();
        n_tests++;
        if (ovf_sticky !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_reset: ovf_sticky=%b, required 0", ovf_sticky);
        end
        ev_if.ev_ready = 1'b1;
        eb = evq.size();
        for (int i = 0; i < 256; i++) fifo.push_back((i % 2 == 1) ? 8'h32 : 8'h1C);
        drain(2000);
        n_tests++;
        if (press_cnt !== 8'd0 || evq.size() - eb != 256 || key_down !== 1'b1 || held_code !== 9'h032) begin
            n_fail++;
            $display("FAIL wrap: cnt=%0d events=%0d down=%b held=%h, required 0 256 1 032", press_cnt, evq.size() - eb, key_down, held_code);
        end
        kbd_overflow = 1'b1;
        tick(1);
        kbd_overflow = 1'b0;
        ev_if.ev_ready = 1'b0;
        eb = evq.size();
        fifo.push_back(8'h21);
        c = 0;
        while (kbd_nextdata_n !== 1'b0 && c < 10) begin
            tick(1);
            c++;
        end
        n_tests++;
        if (c >= 10) begin
            n_fail++;
            $display("FAIL rst_pop_reach: nextdata_n=%b, required 0 within 10 cycles", kbd_nextdata_n);
        end
        rst = 1'b1;
        tick(1);
        n_tests++;
        if (kbd_nextdata_n !== 1'b1 || ev_if.ev_valid !== 1'b0 || key_down !== 1'b0 || held_code !== 9'h000 ||
            press_cnt !== 8'd0 || ovf_sticky !== 1'b0 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_pop: nd_n=%b valid=%b down=%b held=%h cnt=%0d ovf=%b err=%b, required 1 0 0 000 0 0 0",
                     kbd_nextdata_n, ev_if.ev_valid, key_down, held_code, press_cnt, ovf_sticky, err);
        end
        rst = 1'b0;
        tick(6);
        n_tests++;
        if (ev_if.ev_valid !== 1'b0 || evq.size() != eb || press_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL rst_no_partial: valid=%b events=%0d cnt=%0d, required 0 0 0", ev_if.ev_valid, evq.size() - eb, press_cnt);
        end
        ev_if.ev_ready = 1'b1;
    endtask

    initial begin
        rst            = 1'b1;
        kbd_overflow   = 1'b0;
        kbd_ready      = 1'b0;
        kbd_data       = 8'h00;
        ev_if.ev_ready = 1'b1;
        test_reset();
        test_single_make();
        test_repeat();
        test_extended();
        test_backpressure();
        test_errors();
        test_wrap_and_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ps2_kbd_ctrl.md
# ps2_kbd_ctrl

Controller that drains the PS/2 receiver FIFO (`ps2_keyboard`) through its `ready`/`nextdata_n` handshake and decodes raw scan-code bytes into key events. It:
- assembles `E0` (extended) and `F0` (break) prefix sequences into one event per key action;
- tracks the held key to flag typematic repeats and counts distinct presses;
- presents events on a valid/ready interface with backpressure to the consumer (display/CPU glue).

## Interface
Parameters:
- `CNT_W`, default 8: width of press counter.

Ports:
- `clk` input 1: system clock, same clock as `ps2_keyboard`.
- `rst` input 1: synchronous, active-high reset.
- `kbd_data` input 8: FIFO head byte from receiver.
- `kbd_ready` input 1: FIFO non-empty.
- `kbd_overflow` input 1: receiver FIFO overflow flag.
- `kbd_nextdata_n` output 1: active-low pop strobe to receiver.
- `ev_valid` output 1: key event available.
- `ev_ready` input 1: consumer accepts event.
- `ev_code` output 8: scan code, prefixes stripped.
- `ev_ext` output 1: event was `E0`-prefixed.
- `ev_break` output 1: key release (`F0`-prefixed).
- `ev_repeat` output 1: make of the already-held key (typematic).
- `key_down` output 1: a key is currently held.
- `held_code` output 9: `{ext, code}` of the held key.
- `press_cnt` output CNT_W: count of non-repeat make events.
- `ovf_sticky` output 1: `kbd_overflow` was seen high since reset.
- `err` output 1: one-cycle pulse on protocol error.

## Operation
FSM states:
- **WAIT**
  - If `kbd_ready=1` and not (`ev_valid` and not `ev_ready`): latch `kbd_data` into `byte_q`, go to POP.
  - Otherwise stay in WAIT.
- **POP**: `kbd_nextdata_n=0` (combinational from state, the only cycle it is low). Decode `byte_q`, go to SETTLE.
- **SETTLE**: idle for one cycle so the receiver's updated `ready` and `data` are visible. Go to WAIT.

Decode in POP, using prefix flags `ext_f` and `brk_f`:
- `E0`:
  - if `brk_f=1`: `err` pulse, clear `brk_f`, set `ext_f`;
  - else set `ext_f`.
- `F0`: set `brk_f`.
- `00` or `FF` (keyboard error codes): `err` pulse, clear both flags, no event.
- Any other byte: emit event `{ext_f, brk_f, byte}`, then clear both flags.

Key tracking on an emitted event:
- **Make** with `key_down=1` and `{ext,code}==held_code`: `ev_repeat=1`, counter unchanged.
- **Make** otherwise: `held_code` updated, `key_down=1`, `press_cnt` incremented. The counter wraps from all-ones to 0.
- **Break** with `{ext,code}==held_code`: `key_down=0`.
- **Break** of any other key: no change to tracking state.

Event register:
- `ev_*` fields are held stable while `ev_valid=1`.
- `ev_valid` clears on the cycle `ev_ready=1`.
- `ovf_sticky` sets whenever `kbd_overflow=1`. It clears only on reset.

## Timing
- Reset values: state WAIT; `kbd_nextdata_n=1`; `ev_valid=0`; `ev_code=0`; `ev_ext=ev_break=ev_repeat=0`; `key_down=0`; `held_code=0`; `press_cnt=0`; `ovf_sticky=0`; `err=0`; flags cleared.
- A reset asserted in POP must drive `kbd_nextdata_n=1` in the following cycle. No partial byte is retained.
- Throughput: one byte per 3 cycles (WAIT→POP→SETTLE).
- Latency for a byte at the FIFO head with `kbd_ready=1` in cycle t (WAIT):
  - `kbd_nextdata_n=0` in t+1;
  - `ev_valid`, tracking outputs and `err` update at the start of t+2.
- Backpressure: while `ev_valid=1 && ev_ready=0`, no byte is popped, including prefix bytes. The FIFO absorbs input.
- Simultaneous `ev_ready` handshake and a new event in POP: the new event loads and `ev_valid` stays 1. No bubble, no loss.
- `err` is exactly one cycle wide.

## Structure
- Shared package `ps2_pkg`:
  - constants `PS2_EXT=8'hE0`, `PS2_BRK=8'hF0`, `PS2_ERR0=8'h00`, `PS2_ERR1=8'hFF`;
  - FSM state encoding (WAIT/POP/SETTLE);
  - a struct or typedef for the 9-bit `{ext,code}` key id.
- One sub-module: `ps2_key_tracker`, which holds `held_code`, `key_down` and `press_cnt` and computes `ev_repeat`. The top block keeps the FSM, prefix flags and event register.

## Test plan
- Bytes `1C` → one event: code `1C`, ext 0, break 0, repeat 0. `press_cnt=1`, `key_down=1`, `held_code=0x01C`. Check `kbd_nextdata_n` is low exactly one cycle per byte.
- Bytes `1C 1C 1C F0 1C` → events in order:
  - make (repeat 0);
  - make (repeat 1);
  - make (repeat 1);
  - break.
  Final state: `press_cnt=1`, `key_down=0`.
- Bytes `E0 75 E0 F0 75` → make then break, both with code `75` and ext 1. `held_code=0x175`, then `key_down=0`.
- `ev_ready` held low for 20 cycles after the first event while 4 more bytes are queued → no pop occurs, `ev_*` stay stable. After release, all events drain in order.
- Error bytes:
  - `F0 E0` → `err` pulse, and the following `75` yields ext 1, break 0.
  - `FF` → `err` pulse, no event.
  - `kbd_overflow` pulse → `ovf_sticky=1` until `rst`.
- 256 distinct alternating makes (`1C`, `32`, …) → `press_cnt` wraps to 0. Asserting `rst` mid-POP zeroes all outputs next cycle.
